// File: rtl/isdu_pkg.sv
// Shared constants for the LC-3 sequencer: state codes, opcodes and datapath select encodings.
package isdu_pkg;

  localparam int SW = 5;

  localparam logic [SW-1:0] S_HALTED = 5'd0,  S_F18   = 5'd1,  S_F33   = 5'd2,  S_F35   = 5'd3;
  localparam logic [SW-1:0] S_D32    = 5'd4,  S_ADD   = 5'd5,  S_AND   = 5'd6,  S_NOT   = 5'd7;
  localparam logic [SW-1:0] S_BR00   = 5'd8,  S_BR22  = 5'd9,  S_JMP12 = 5'd10, S_JSR04 = 5'd11;
  localparam logic [SW-1:0] S_JSR21  = 5'd12, S_LDR06 = 5'd13, S_R25   = 5'd14, S_LDR27 = 5'd15;
  localparam logic [SW-1:0] S_STR07  = 5'd16, S_STR23 = 5'd17, S_W16   = 5'd18, S_LEA14 = 5'd19;
  localparam logic [SW-1:0] S_LDI10  = 5'd20, S_LDI_M = 5'd21, S_STI11 = 5'd22, S_STI_M = 5'd23;
  localparam logic [SW-1:0] S_PAUSE1 = 5'd24, S_PAUSE2 = 5'd25;

  localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_JSR = 4'b0100, OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001, OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011, OP_JMP = 4'b1100, OP_PSE = 4'b1101, OP_LEA = 4'b1110;

  localparam logic [1:0] PCMUX_INC = 2'b00, PCMUX_BUS = 2'b01, PCMUX_ADDR = 2'b10;
  localparam logic [1:0] A2_ZERO = 2'b00, A2_OFF6 = 2'b01, A2_OFF9 = 2'b10, A2_OFF11 = 2'b11;
  localparam logic [1:0] ALUK_ADD = 2'b00, ALUK_AND = 2'b01, ALUK_NOT = 2'b10, ALUK_PASSA = 2'b11;
  localparam logic [1:0] SR1_DR = 2'b00, SR1_BASE = 2'b01;
  localparam logic [1:0] DR_IR = 2'b00, DR_R7 = 2'b01;

  function automatic logic is_access(logic [SW-1:0] s);
    return (s == S_F33) || (s == S_R25) || (s == S_W16);
  endfunction

endpackage

// File: rtl/isdu_wait_ctr.sv
// Counts cycles spent in an SRAM access state; done marks the completing cycle.
module isdu_wait_ctr #(
  parameter int MEM_WAIT = 3,
  parameter int USE_RDY  = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic active,
  input  logic mem_rdy,
  output logic done
);
  localparam int CW = $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == LAST);
  assign done    = active && at_last && ((USE_RDY == 0) || mem_rdy);

  // Saturate at the last count while waiting on ready; never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt <= '0;
    else if (start || !active || done) cnt <= '0;
    else if (!at_last)                 cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/isdu_param.sv
// LC-3 instruction sequencer/decoder with counted SRAM access states and optional ready handshake.
module isdu_param
  import isdu_pkg::*;
#(
  parameter int MEM_WAIT = 3,
  parameter int USE_RDY  = 0,
  parameter int PAUSE_EN = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  input  logic       Mem_Rdy,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic       ADDR1MUX,
  output logic       SR2MUX,
  output logic [1:0] PCMUX,
  output logic [1:0] DRMUX,
  output logic [1:0] SR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Busy
);
  logic [SW-1:0] state, nxt;
  logic          ind;
  logic          done;

  isdu_wait_ctr #(.MEM_WAIT(MEM_WAIT), .USE_RDY(USE_RDY)) u_wait (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .start   (is_access(nxt) && !is_access(state)),
    .active  (is_access(state)),
    .mem_rdy (Mem_Rdy),
    .done    (done)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_HALTED;
    else          state <= nxt;
  end

  // Second-pass flag: LDI walks R25 twice, the second read delivers the data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)               ind <= 1'b0;
    else if (state == S_LDI_M)  ind <= 1'b1;
    else if (state == S_F18)    ind <= 1'b0;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_HALTED: if (Run) nxt = S_F18;
      S_F18:    nxt = S_F33;
      S_F33:    if (done) nxt = S_F35;
      S_F35:    nxt = S_D32;
      S_D32: begin
        case (Opcode)
          OP_ADD:  nxt = S_ADD;
          OP_AND:  nxt = S_AND;
          OP_NOT:  nxt = S_NOT;
          OP_BR:   nxt = S_BR00;
          OP_JMP:  nxt = S_JMP12;
          OP_JSR:  nxt = S_JSR04;
          OP_LDR:  nxt = S_LDR06;
          OP_STR:  nxt = S_STR07;
          OP_LEA:  nxt = S_LEA14;
          OP_LDI:  nxt = S_LDI10;
          OP_STI:  nxt = S_STI11;
          OP_PSE:  nxt = (PAUSE_EN != 0) ? S_PAUSE1 : S_F18;
          default: nxt = S_F18;
        endcase
      end
      S_ADD, S_AND, S_NOT, S_BR22, S_JMP12, S_JSR21, S_LEA14, S_LDR27: nxt = S_F18;
      S_BR00:  nxt = BEN ? S_BR22 : S_F18;
      S_JSR04: nxt = S_JSR21;
      S_LDR06, S_LDI10, S_STI11, S_LDI_M: nxt = S_R25;
      S_R25: begin
        if (done) begin
          if (Opcode == OP_LDI)      nxt = ind ? S_LDR27 : S_LDI_M;
          else if (Opcode == OP_STI) nxt = S_STI_M;
          else                       nxt = S_LDR27;
        end
      end
      S_STR07, S_STI_M: nxt = S_STR23;
      S_STR23: nxt = S_W16;
      S_W16:   if (done) nxt = S_F18;
      S_PAUSE1: if (Continue)  nxt = S_PAUSE2;
      S_PAUSE2: if (!Continue) nxt = S_F18;
      default: nxt = S_HALTED;
    endcase
  end

  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;
  assign Mem_OE = !is_access(state);
  assign Mem_WE = (state != S_W16);
  assign Busy   = (state != S_HALTED);

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC  = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    ADDR1MUX = 1'b0; SR2MUX = 1'b0;
    PCMUX = PCMUX_INC; DRMUX = DR_IR; SR1MUX = SR1_DR; ADDR2MUX = A2_ZERO; ALUK = ALUK_ADD;
    case (state)
      S_F18:        begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = PCMUX_INC; end
      S_F33, S_R25: LD_MDR = done;
      S_F35:        begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S_D32:        LD_BEN = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; SR1MUX = SR1_BASE;
        ALUK    = (state == S_ADD) ? ALUK_ADD : (state == S_AND) ? ALUK_AND : ALUK_NOT;
        SR2MUX  = (state != S_NOT) && IR_5;
      end
      S_BR22:  begin ADDR2MUX = A2_OFF9; PCMUX = PCMUX_ADDR; LD_PC = 1'b1; end
      S_JMP12: begin SR1MUX = SR1_BASE; ADDR1MUX = 1'b1; ADDR2MUX = A2_ZERO; PCMUX = PCMUX_ADDR; LD_PC = 1'b1; end
      S_JSR04: begin GatePC = 1'b1; LD_REG = 1'b1; DRMUX = DR_R7; end
      S_JSR21: begin
        LD_PC = 1'b1; PCMUX = PCMUX_ADDR;
        if (IR_11) begin ADDR2MUX = A2_OFF11; ADDR1MUX = 1'b0; end
        else begin ADDR2MUX = A2_ZERO; ADDR1MUX = 1'b1; SR1MUX = SR1_BASE; end
      end
      S_LDR06, S_STR07: begin
        SR1MUX = SR1_BASE; ADDR1MUX = 1'b1; ADDR2MUX = A2_OFF6; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S_LDI10, S_STI11: begin ADDR2MUX = A2_OFF9; GateMARMUX = 1'b1; LD_MAR = 1'b1; end
      S_LDI_M, S_STI_M: begin GateMDR = 1'b1; LD_MAR = 1'b1; end
      S_LDR27: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S_STR23: begin SR1MUX = SR1_DR; ALUK = ALUK_PASSA; GateALU = 1'b1; LD_MDR = 1'b1; end
      S_LEA14: begin ADDR2MUX = A2_OFF9; GateMARMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S_PAUSE1, S_PAUSE2: LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_isdu_param.sv
// Bench for isdu_param: three parameter sets, table-driven per-instruction totals, hand corner cases,
// and random instruction streams checked cycle by cycle against an expected control-word trace.
module tb_isdu_param;

  localparam int NI = 3;
  localparam int MWA [NI] = '{3, 2, 1};
  localparam int URA [NI] = '{0, 1, 1};
  localparam int PEA [NI] = '{1, 0, 1};

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic addr1mux, sr2mux;
    logic [1:0] pcmux, drmux, sr1mux, addr2mux, aluk;
    logic ce, ub, lb, oe, we, busy;
  } cw_t;

  typedef struct { cw_t cw; logic run, cont, rdy; } step_t;

  typedef struct { logic [3:0] op; logic b; int len, oe, we, ldreg, ldpc, ldmdr; } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic run [NI], cont [NI], ir5 [NI], ir11 [NI], ben [NI], rdy [NI];
  logic [3:0] opc [NI];
  logic ld_mar [NI], ld_mdr [NI], ld_ir [NI], ld_ben [NI], ld_cc [NI], ld_reg [NI], ld_pc [NI], ld_led [NI];
  logic gate_pc [NI], gate_mdr [NI], gate_alu [NI], gate_marmux [NI], addr1mux [NI], sr2mux [NI];
  logic [1:0] pcmux [NI], drmux [NI], sr1mux [NI], addr2mux [NI], aluk [NI];
  logic mem_ce [NI], mem_ub [NI], mem_lb [NI], mem_oe [NI], mem_we [NI], busy [NI];
  cw_t dut_cw [NI];

  int n_checks, n_fail;
  step_t q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    isdu_param #(.MEM_WAIT(MWA[g]), .USE_RDY(URA[g]), .PAUSE_EN(PEA[g])) u_dut (
      .Clk(clk), .Reset_n(rst_n), .Run(run[g]), .Continue(cont[g]), .Opcode(opc[g]),
      .IR_5(ir5[g]), .IR_11(ir11[g]), .BEN(ben[g]), .Mem_Rdy(rdy[g]),
      .LD_MAR(ld_mar[g]), .LD_MDR(ld_mdr[g]), .LD_IR(ld_ir[g]), .LD_BEN(ld_ben[g]),
      .LD_CC(ld_cc[g]), .LD_REG(ld_reg[g]), .LD_PC(ld_pc[g]), .LD_LED(ld_led[g]),
      .GatePC(gate_pc[g]), .GateMDR(gate_mdr[g]), .GateALU(gate_alu[g]), .GateMARMUX(gate_marmux[g]),
      .ADDR1MUX(addr1mux[g]), .SR2MUX(sr2mux[g]), .PCMUX(pcmux[g]), .DRMUX(drmux[g]),
      .SR1MUX(sr1mux[g]), .ADDR2MUX(addr2mux[g]), .ALUK(aluk[g]),
      .Mem_CE(mem_ce[g]), .Mem_UB(mem_ub[g]), .Mem_LB(mem_lb[g]), .Mem_OE(mem_oe[g]),
      .Mem_WE(mem_we[g]), .Busy(busy[g])
    );
    assign dut_cw[g] = {ld_mar[g], ld_mdr[g], ld_ir[g], ld_ben[g], ld_cc[g], ld_reg[g], ld_pc[g], ld_led[g],
                        gate_pc[g], gate_mdr[g], gate_alu[g], gate_marmux[g], addr1mux[g], sr2mux[g],
                        pcmux[g], drmux[g], sr1mux[g], addr2mux[g], aluk[g],
                        mem_ce[g], mem_ub[g], mem_lb[g], mem_oe[g], mem_we[g], busy[g]};
  end

  task automatic check(string name, int g, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h", name, g, got, exp);
    end
  endtask

  function automatic cw_t halted();
    cw_t c = '0;
    c.oe = 1'b1; c.we = 1'b1;
    return c;
  endfunction

  function automatic cw_t base();
    cw_t c = halted();
    c.busy = 1'b1;
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic push(cw_t c, logic cv, logic rv);
    step_t s;
    s.cw = c; s.run = rb(); s.cont = cv; s.rdy = rv;
    q.push_back(s);
  endtask

  // One SRAM access: MEM_WAIT strobed cycles, plus ready stalls on the last one when the handshake is on.
  task automatic push_access(int g, bit wr);
    cw_t c = base();
    int  stall = (URA[g] != 0) ? int'($urandom_range(0, 4)) : 0;
    c.oe = 1'b0;
    if (wr) c.we = 1'b0;
    for (int j = 0; j < MWA[g] - 1; j++) push(c, rb(), rb());
    for (int k = 0; k < stall; k++) push(c, rb(), 1'b0);
    c.ld_mdr = !wr;
    push(c, rb(), (URA[g] != 0) ? 1'b1 : rb());
  endtask

  function automatic cw_t mar_calc(bit pc_rel);
    cw_t c = base();
    c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
    if (pc_rel) c.addr2mux = 2'b10;
    else begin c.sr1mux = 2'b01; c.addr1mux = 1'b1; c.addr2mux = 2'b01; end
    return c;
  endfunction

  task automatic build_instr(int g, logic [3:0] op, logic i5, logic i11, logic b);
    cw_t c, st, mm;
    c = base(); c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; push(c, rb(), rb());
    push_access(g, 0);
    c = base(); c.gate_mdr = 1; c.ld_ir = 1; push(c, rb(), rb());
    c = base(); c.ld_ben = 1; push(c, rb(), rb());
    st = base(); st.aluk = 2'b11; st.gate_alu = 1; st.ld_mdr = 1;
    mm = base(); mm.gate_mdr = 1; mm.ld_mar = 1;
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        c = base(); c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.sr1mux = 2'b01;
        c.aluk = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
        c.sr2mux = (op != 4'b1001) ? i5 : 1'b0;
        push(c, rb(), rb());
      end
      4'b0000: begin
        push(base(), rb(), rb());
        if (b) begin c = base(); c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1; push(c, rb(), rb()); end
      end
      4'b1100: begin
        c = base(); c.sr1mux = 2'b01; c.addr1mux = 1; c.pcmux = 2'b10; c.ld_pc = 1; push(c, rb(), rb());
      end
      4'b0100: begin
        c = base(); c.gate_pc = 1; c.ld_reg = 1; c.drmux = 2'b01; push(c, rb(), rb());
        c = base(); c.ld_pc = 1; c.pcmux = 2'b10;
        if (i11) c.addr2mux = 2'b11;
        else begin c.addr1mux = 1; c.sr1mux = 2'b01; end
        push(c, rb(), rb());
      end
      4'b0110, 4'b1010: begin
        push(mar_calc(op == 4'b1010), rb(), rb());
        push_access(g, 0);
        if (op == 4'b1010) begin push(mm, rb(), rb()); push_access(g, 0); end
        c = base(); c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; push(c, rb(), rb());
      end
      4'b0111, 4'b1011: begin
        push(mar_calc(op == 4'b1011), rb(), rb());
        if (op == 4'b1011) begin push_access(g, 0); push(mm, rb(), rb()); end
        push(st, rb(), rb());
        push_access(g, 1);
      end
      4'b1110: begin
        c = base(); c.addr2mux = 2'b10; c.gate_marmux = 1; c.ld_reg = 1; c.ld_cc = 1; push(c, rb(), rb());
      end
      4'b1101: if (PEA[g] != 0) begin
        int n1 = int'($urandom_range(0, 3));
        int n2 = int'($urandom_range(0, 3));
        c = base(); c.ld_led = 1;
        for (int k = 0; k < n1; k++) push(c, 1'b0, rb());
        push(c, 1'b1, rb());
        for (int k = 0; k < n2; k++) push(c, 1'b1, rb());
        push(c, 1'b0, rb());
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      run[g] = 0; cont[g] = 0; ir5[g] = 0; ir11[g] = 0; ben[g] = 0; rdy[g] = 0; opc[g] = '0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_random(int g, int n);
    step_t s;
    int    f0;
    do_reset();
    q.delete();
    s.cw = halted(); s.run = 1'b1; s.cont = rb(); s.rdy = rb();
    q.push_back(s);
    for (int i = 0; i < n; i++) begin
      opc[g]  = (i < 16) ? 4'(i) : 4'($urandom);
      ir5[g]  = rb(); ir11[g] = rb(); ben[g] = rb();
      build_instr(g, opc[g], ir5[g], ir11[g], ben[g]);
      while (q.size() > 0) begin
        s = q.pop_front();
        run[g] = s.run; cont[g] = s.cont; rdy[g] = s.rdy;
        @(negedge clk);
        f0 = n_fail;
        check($sformatf("trace op%b", opc[g]), g, 32'(dut_cw[g]), 32'(s.cw));
        @(posedge clk); #1;
        if (n_fail != f0) begin run[g] = 0; return; end
      end
    end
    run[g] = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [14];
    int   len, noe, nwe, nreg, npc, nmdr, mdr_at;
    n_checks = 0; n_fail = 0;
    tbl = '{'{4'b0001, 0, 7, 3, 0, 1, 1, 1},  '{4'b1001, 0, 7, 3, 0, 1, 1, 1},
            '{4'b0101, 0, 7, 3, 0, 1, 1, 1},  '{4'b0000, 0, 7, 3, 0, 0, 1, 1},
            '{4'b0000, 1, 8, 3, 0, 0, 2, 1},  '{4'b1100, 0, 7, 3, 0, 0, 2, 1},
            '{4'b0100, 0, 8, 3, 0, 1, 2, 1},  '{4'b0110, 0, 11, 6, 0, 1, 1, 2},
            '{4'b0111, 0, 11, 6, 3, 0, 1, 2}, '{4'b1110, 0, 7, 3, 0, 1, 1, 1},
            '{4'b1010, 0, 15, 9, 0, 1, 1, 3}, '{4'b1011, 0, 15, 9, 3, 0, 1, 3},
            '{4'b1000, 0, 6, 3, 0, 0, 1, 1},  '{4'b1111, 1, 6, 3, 0, 0, 1, 1}};

    // Reset state, then reset asserted in the middle of a fetch read.
    do_reset();
    rst_n = 1'b0;
    #2;
    for (int g = 0; g < NI; g++) check("reset_cw", g, 32'(dut_cw[g]), 32'(halted()));
    @(posedge clk); #1;
    rst_n = 1'b1; run[0] = 1;
    @(posedge clk); #1;
    run[0] = 0;
    check("f18_entry", 0, {gate_pc[0], ld_mar[0], ld_pc[0], busy[0]}, 4'b1111);
    @(posedge clk); #1;
    check("f33_oe_low", 0, mem_oe[0], 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_oe", 0, mem_oe[0], 1);
    check("rst_async_busy", 0, busy[0], 0);
    check("rst_no_ldmdr", 0, ld_mdr[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1; run[0] = 1;
    @(posedge clk); #1;
    run[0] = 0;
    check("rst_run_f18", 0, {gate_pc[0], ld_mar[0], busy[0]}, 3'b111);

    // Per-instruction totals from F18 to the next F18 (MEM_WAIT=3, no handshake).
    do_reset();
    run[0] = 1;
    @(posedge clk); #1;
    run[0] = 0;
    for (int i = 0; i < 14; i++) begin
      opc[0] = tbl[i].op; ben[0] = tbl[i].b; ir5[0] = rb(); ir11[0] = rb(); rdy[0] = rb();
      len = 0; noe = 0; nwe = 0; nreg = 0; npc = 0; nmdr = 0;
      do begin
        @(negedge clk);
        noe += int'(!mem_oe[0]); nwe += int'(!mem_we[0]);
        nreg += int'(ld_reg[0]); npc += int'(ld_pc[0]); nmdr += int'(ld_mdr[0]);
        @(posedge clk); #1;
        len++;
      end while (!(gate_pc[0] && ld_mar[0]) && len < 50);
      check($sformatf("len op%b", tbl[i].op), 0, len, tbl[i].len);
      check($sformatf("oe_cyc op%b", tbl[i].op), 0, noe, tbl[i].oe);
      check($sformatf("we_cyc op%b", tbl[i].op), 0, nwe, tbl[i].we);
      check($sformatf("ld_reg op%b", tbl[i].op), 0, nreg, tbl[i].ldreg);
      check($sformatf("ld_pc op%b", tbl[i].op), 0, npc, tbl[i].ldpc);
      check($sformatf("ld_mdr op%b", tbl[i].op), 0, nmdr, tbl[i].ldmdr);
    end

    // Handshake: MEM_WAIT=2 with Mem_Rdy low for the first 5 cycles of the fetch read.
    do_reset();
    run[1] = 1;
    @(posedge clk); #1;
    run[1] = 0;
    @(posedge clk); #1;
    noe = 0; nmdr = 0; mdr_at = -1;
    for (int k = 0; k < 20; k++) begin
      rdy[1] = (k >= 5);
      @(negedge clk);
      if (mem_oe[1]) break;
      noe++;
      if (ld_mdr[1]) begin nmdr++; mdr_at = k; end
      @(posedge clk); #1;
    end
    check("rdy_f33_cycles", 1, noe, 6);
    check("rdy_ldmdr_count", 1, nmdr, 1);
    check("rdy_ldmdr_cycle", 1, mdr_at, 5);

    for (int g = 0; g < NI; g++) run_random(g, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
